sigma_delta_adc: RTL and testbench

- Receive side of the first-order sigma-delta link; the counterpart of the sigma-delta DAC.
- Samples an external 1-bit comparator bitstream and drives the feedback bit for the external RC integrator.
- Decimates the bitstream with a sinc^3 (3-stage CIC) filter into unsigned OUTW-bit PCM samples.
- Delivers samples to the audio/tape capture logic over a valid/ready handshake.

---
 rtl/sigma_delta_adc.sv | 138 +++++++++++++
 tb/tb_sigma_delta_adc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_adc.sv
// Sigma-delta ADC receive path: comparator synchronizer, integrator feedback bit,
// sinc^3 decimator and a single-entry valid/ready output buffer with overrun flag.
module sigma_delta_adc #(
    parameter int   DECIM_LOG2 = 6,
    parameter int   OUTW       = 16,
    parameter logic INV        = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            DSIN,
    output logic            DSOUT,
    output logic [OUTW-1:0] OUT_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic            OVERRUN
);
    localparam int FS = 3 * DECIM_LOG2;
    localparam int W  = FS + 1;

    logic                  sync1_q, sync2_q, dsout_q;
    logic                  x;
    logic [W-1:0]          int1_q, int2_q, int3_q;
    logic [W-1:0]          int1_d, int2_d, int3_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  strobe;
    logic                  stb1_q, stb2_q;
    logic [W-1:0]          cap_q, dly1_q, dly2_q, dly3_q, comb_q;
    logic [W-1:0]          c1, c2, c3;
    logic [1:0]            prime_q, prime_d;
    logic [FS-1:0]         sat;
    logic [OUTW-1:0]       scaled;
    logic                  deliver;
    logic [OUTW-1:0]       data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;

    assign x = sync2_q ^ INV;

    assign int1_d = int1_q + {{(W-1){1'b0}}, x};
    assign int2_d = int2_q + int1_q;
    assign int3_d = int3_q + int2_q;

    assign cnt_d  = cnt_q + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
    assign strobe = (cnt_q == {DECIM_LOG2{1'b1}});

    assign c1 = cap_q - dly1_q;
    assign c2 = c1 - dly2_q;
    assign c3 = c2 - dly3_q;

    // Only exact full scale (R^3) can set the top bit; clip it to one LSB below.
    assign sat = comb_q[W-1] ? '1 : comb_q[FS-1:0];

    generate
        if (FS >= OUTW) begin : g_trunc
            assign scaled = sat[FS-1 -: OUTW];
            if (FS > OUTW) begin : g_drop
                logic unused_lsbs;
                assign unused_lsbs = ^sat[FS-OUTW-1:0];
            end
        end else begin : g_pad
            assign scaled = {sat, {(OUTW-FS){1'b0}}};
        end
    endgenerate

    always_comb begin
        prime_d   = prime_q;
        deliver   = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (stb2_q) begin
            if (prime_q != 2'd3) begin
                prime_d = prime_q + 2'd1;
            end else begin
                deliver = 1'b1;
            end
        end
        if (deliver) begin
            data_d    = scaled;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~OUT_READY;
        end else if (valid_q && OUT_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            dsout_q   <= 1'b0;
            int1_q    <= '0;
            int2_q    <= '0;
            int3_q    <= '0;
            cnt_q     <= '0;
            stb1_q    <= 1'b0;
            stb2_q    <= 1'b0;
            cap_q     <= '0;
            dly1_q    <= '0;
            dly2_q    <= '0;
            dly3_q    <= '0;
            comb_q    <= '0;
            prime_q   <= 2'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= DSIN;
            sync2_q   <= sync1_q;
            dsout_q   <= x;
            int1_q    <= int1_d;
            int2_q    <= int2_d;
            int3_q    <= int3_d;
            cnt_q     <= cnt_d;
            stb1_q    <= strobe;
            stb2_q    <= stb1_q;
            if (strobe) begin
                cap_q <= int3_q;
            end
            if (stb1_q) begin
                dly1_q <= cap_q;
                dly2_q <= c1;
                dly3_q <= c2;
                comb_q <= c3;
            end
            prime_q   <= prime_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign DSOUT     = dsout_q;
    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc: one normal and one inverted-input instance
// driven from the same bitstream, checked against hand-derived sample values.
module tb_sigma_delta_adc;
    localparam int R = 64;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        DSIN = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        dsout, valid, ovr;
    logic [15:0] data;
    logic        dsout_n, valid_n, ovr_n;
    logic [15:0] data_n;

    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   ncyc = 0;
    int   pat = 0;
    logic hist [4];

    always #5 CLK = ~CLK;

    sigma_delta_adc #(.DECIM_LOG2(6), .OUTW(16), .INV(1'b0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DSIN(DSIN), .DSOUT(dsout),
        .OUT_DATA(data), .OUT_VALID(valid), .OUT_READY(OUT_READY), .OVERRUN(ovr)
    );

    sigma_delta_adc #(.DECIM_LOG2(6), .OUTW(16), .INV(1'b1)) dut_inv (
        .CLK(CLK), .RESET_N(RESET_N), .DSIN(DSIN), .DSOUT(dsout_n),
        .OUT_DATA(data_n), .OUT_VALID(valid_n), .OUT_READY(OUT_READY), .OVERRUN(ovr_n)
    );

    // 0: all zero, 1: all one, 2: 1,0,1,0..., 3: 1,0,0,0...
    function automatic logic pat_val(input int p, input int n);
        case (p)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((n % 2) == 0);
            default: return ((n % 4) == 0);
        endcase
    endfunction

    // Edge ncyc has just happened; DSIN for the following cycle is driven here.
    task automatic step();
        @(posedge CLK);
        #1;
        ncyc++;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        DSIN = pat_val(pat, ncyc);
        hist[0] = DSIN;
    endtask

    task automatic run_to(input int e);
        while (ncyc < e) step();
    endtask

    // Release lands between edges; the first edge afterwards is ncyc = 1.
    // Deliveries land on edges j*R+2, the first visible one being j = 4.
    task automatic do_reset(input int p);
        RESET_N = 1'b0;
        pat = p;
        DSIN = 1'b0;
        #12;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        ncyc = 0;
        DSIN = pat_val(p, 0);
        for (int i = 0; i < 4; i++) hist[i] = 1'b0;
        hist[0] = DSIN;
    endtask

    task automatic test_reset();
        int bad;
        RESET_N = 1'b0;
        DSIN = 1'b1;
        OUT_READY = 1'b1;
        #23;
        chk_cnt++;
        if ({dsout, valid, ovr, data} !== 19'd0)
            $display("FAIL reset_outputs: got %b want 0", {dsout, valid, ovr, data});
        else pass_cnt++;
        chk_cnt++;
        if ({dsout_n, valid_n, ovr_n, data_n} !== 19'd0)
            $display("FAIL reset_outputs_inv: got %b want 0", {dsout_n, valid_n, ovr_n, data_n});
        else pass_cnt++;

        do_reset(1);
        bad = 0;
        while (ncyc < 4*R+1) begin
            step();
            if (valid !== 1'b0 || ovr !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL priming_quiet: got %0d early valid/overrun cycles want 0", bad);
        else pass_cnt++;

        step();
        chk_cnt++;
        if (valid !== 1'b1 || data !== 16'hFFFF)
            $display("FAIL first_sample: got valid=%b data=%h want valid=1 data=ffff", valid, data);
        else pass_cnt++;
        chk_cnt++;
        if (valid_n !== 1'b1 || data_n !== 16'h0000)
            $display("FAIL first_sample_inv: got valid=%b data=%h want valid=1 data=0000", valid_n, data_n);
        else pass_cnt++;

        step();
        chk_cnt++;
        if (valid !== 1'b0) $display("FAIL consume_clears: got valid=%b want 0", valid);
        else pass_cnt++;

        for (int j = 5; j <= 7; j++) begin
            run_to(j*R+1);
            chk_cnt++;
            if (valid !== 1'b0) $display("FAIL period_early j=%0d: got valid=%b want 0", j, valid);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (valid !== 1'b1 || data !== 16'hFFFF || ovr !== 1'b0)
                $display("FAIL period_sample j=%0d: got valid=%b data=%h ovr=%b want 1/ffff/0",
                         j, valid, data, ovr);
            else pass_cnt++;
        end
    endtask

    task automatic test_const0();
        OUT_READY = 1'b1;
        do_reset(0);
        run_to(4*R+2);
        chk_cnt++;
        if (valid !== 1'b1 || data !== 16'h0000)
            $display("FAIL zero_stream: got valid=%b data=%h want 1/0000", valid, data);
        else pass_cnt++;
        chk_cnt++;
        if (valid_n !== 1'b1 || data_n !== 16'hFFFF)
            $display("FAIL zero_stream_inv: got valid=%b data=%h want 1/ffff", valid_n, data_n);
        else pass_cnt++;
    endtask

    task automatic test_patterns(input int p, input logic [15:0] exp, input logic [15:0] exp_n);
        int mism;
        OUT_READY = 1'b1;
        do_reset(p);
        mism = 0;
        while (ncyc < 5*R+2) begin
            step();
            if (ncyc >= 3 && (dsout !== hist[3] || dsout_n !== ~hist[3])) mism++;
        end
        chk_cnt++;
        if (mism != 0) $display("FAIL dsout_delay p=%0d: got %0d mismatching cycles want 0", p, mism);
        else pass_cnt++;
        chk_cnt++;
        if (valid !== 1'b1 || data !== exp)
            $display("FAIL pattern_data p=%0d: got valid=%b data=%h want 1/%h", p, valid, data, exp);
        else pass_cnt++;
        chk_cnt++;
        if (data_n !== exp_n)
            $display("FAIL pattern_data_inv p=%0d: got %h want %h", p, data_n, exp_n);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int pulses;
        OUT_READY = 1'b1;
        do_reset(2);
        run_to(5*R+3);
        chk_cnt++;
        if (valid !== 1'b0) $display("FAIL ovr_setup: got valid=%b want 0", valid);
        else pass_cnt++;
        OUT_READY = 1'b0;
        pulses = 0;
        while (ncyc < 7*R+3) begin
            step();
            if (ovr === 1'b1) pulses++;
            if (ncyc == 6*R+2) begin
                chk_cnt++;
                if (valid !== 1'b1 || ovr !== 1'b0)
                    $display("FAIL ovr_first: got valid=%b ovr=%b want 1/0", valid, ovr);
                else pass_cnt++;
            end
            if (ncyc == 7*R+2) begin
                chk_cnt++;
                if (ovr !== 1'b1 || data !== 16'h8000)
                    $display("FAIL ovr_second: got ovr=%b data=%h want 1/8000", ovr, data);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (pulses != 1 || ovr !== 1'b0)
            $display("FAIL ovr_pulse: got pulses=%0d ovr_now=%b want 1/0", pulses, ovr);
        else pass_cnt++;

        pat = 0;
        run_to(12*R+3);
        chk_cnt++;
        if (valid !== 1'b1 || data !== 16'h0000)
            $display("FAIL ovr_newer: got valid=%b data=%h want 1/0000", valid, data);
        else pass_cnt++;
        OUT_READY = 1'b1;
        step();
        chk_cnt++;
        if (valid !== 1'b0) $display("FAIL ovr_release: got valid=%b want 0", valid);
        else pass_cnt++;
        OUT_READY = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_to(13*R+2);
        chk_cnt++;
        if (valid !== 1'b1 || ovr !== 1'b0)
            $display("FAIL b2b_load: got valid=%b ovr=%b want 1/0", valid, ovr);
        else pass_cnt++;
        run_to(14*R+1);
        OUT_READY = 1'b1;
        step();
        chk_cnt++;
        if (valid !== 1'b1 || ovr !== 1'b0 || data !== 16'h0000)
            $display("FAIL b2b_same_cycle: got valid=%b ovr=%b data=%h want 1/0/0000", valid, ovr, data);
        else pass_cnt++;
        OUT_READY = 1'b0;
        step();
        chk_cnt++;
        if (valid !== 1'b1) $display("FAIL b2b_kept: got valid=%b want 1", valid);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int bad;
        #2;
        RESET_N = 1'b0;
        #1;
        chk_cnt++;
        if ({dsout, valid, ovr, data} !== 19'd0)
            $display("FAIL mid_reset: got %b want 0", {dsout, valid, ovr, data});
        else pass_cnt++;
        chk_cnt++;
        if ({dsout_n, valid_n, ovr_n, data_n} !== 19'd0)
            $display("FAIL mid_reset_inv: got %b want 0", {dsout_n, valid_n, ovr_n, data_n});
        else pass_cnt++;
        OUT_READY = 1'b1;
        do_reset(1);
        bad = 0;
        while (ncyc < 4*R+1) begin
            step();
            if (valid !== 1'b0 || ovr !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL reprime_quiet: got %0d early valid/overrun cycles want 0", bad);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (valid !== 1'b1 || data !== 16'hFFFF || ovr !== 1'b0)
            $display("FAIL reprime_sample: got valid=%b data=%h ovr=%b want 1/ffff/0", valid, data, ovr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_const0();
        test_patterns(2, 16'h8000, 16'h8000);
        test_patterns(3, 16'h4000, 16'hC000);
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
